// File: rtl/edge_activity_counter.sv
// Switching-activity monitor: counts synchronised 0->1 transitions per probe
// channel, keeps a saturating total, and serves snapshots over a 4-phase read port.
//
// state | meaning
// IDLE  | no read in progress, waiting for rd_req
// SNAP  | request accepted, channel select latched, snapshot taken on next edge
// ACK   | rd_ack high, rd_data held until rd_req is seen low
module edge_activity_counter #(
   parameter int N_CH  = 4,
   parameter int CNT_W = 16,
   parameter int SEL_W = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enb,
   input  logic [N_CH-1:0]  probe,
   input  logic             clr,
   input  logic             rd_req,
   input  logic [SEL_W-1:0] rd_sel,
   output logic             rd_ack,
   output logic [CNT_W-1:0] rd_data,
   output logic [N_CH-1:0]  sat,
   output logic [CNT_W-1:0] total
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SNAP = 2'd1,
      ACK  = 2'd2
   } rd_state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   rd_state_t        state, state_nxt;
   logic [N_CH-1:0]  s1, s2, prev;
   logic [N_CH-1:0]  inc;
   logic [CNT_W-1:0] cnt     [N_CH];
   logic [CNT_W-1:0] cnt_nxt [N_CH];
   logic [N_CH-1:0]  sat_nxt;
   logic [CNT_W:0]   pop;
   logic [CNT_W:0]   total_sum;
   logic [CNT_W-1:0] total_nxt;
   logic [SEL_W-1:0] sel_q;
   logic [CNT_W-1:0] snap;
   logic             ld_sel, ld_snap, drop_ack;

   // Sync chain runs regardless of enb so a stale level never looks like an edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1   <= '0;
         s2   <= '0;
         prev <= '0;
      end else begin
         s1   <= probe;
         s2   <= s1;
         prev <= s2;
      end
   end

   assign inc = s2 & ~prev & {N_CH{enb}};

   always_comb begin
      cnt_nxt = cnt;
      sat_nxt = sat;
      pop     = '0;
      for (int i = 0; i < N_CH; i++) begin
         if (inc[i]) begin
            pop = pop + 1'b1;
            if (cnt[i] != CNT_MAX) cnt_nxt[i] = cnt[i] + 1'b1;
         end
         if (cnt_nxt[i] == CNT_MAX) sat_nxt[i] = 1'b1;
      end
      total_sum = {1'b0, total} + pop;
      total_nxt = total_sum[CNT_W] ? CNT_MAX : total_sum[CNT_W-1:0];
      // Clear wins over any increment landing on the same edge.
      if (clr) begin
         for (int i = 0; i < N_CH; i++) cnt_nxt[i] = '0;
         sat_nxt   = '0;
         total_nxt = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt   <= '{default: '0};
         sat   <= '0;
         total <= '0;
      end else begin
         cnt   <= cnt_nxt;
         sat   <= sat_nxt;
         total <= total_nxt;
      end
   end

   // Out-of-range selects fall through to zero.
   always_comb begin
      snap = '0;
      for (int i = 0; i < N_CH; i++) begin
         if (sel_q == SEL_W'(i)) snap = cnt[i];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      ld_sel    = 1'b0;
      ld_snap   = 1'b0;
      drop_ack  = 1'b0;
      case (state)
         IDLE: begin
            if (rd_req) begin
               ld_sel    = 1'b1;
               state_nxt = SNAP;
            end
         end
         SNAP: begin
            ld_snap   = 1'b1;
            state_nxt = ACK;
         end
         ACK: begin
            if (!rd_req) begin
               drop_ack  = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sel_q   <= '0;
         rd_data <= '0;
         rd_ack  <= 1'b0;
      end else begin
         if (ld_sel) sel_q <= rd_sel;
         if (ld_snap) begin
            rd_data <= snap;
            rd_ack  <= 1'b1;
         end
         if (drop_ack) rd_ack <= 1'b0;
      end
   end

endmodule
